bist_signature_checker: RTL and testbench
=========================================

BIST_SIGNATURE_CHECKER -- requirements
Module: bist_signature_checker

Interface
REQ-001: Parameter SIG_W, 16, signature register width in bits.
REQ-002: Parameter POLY, 16'h1021, feedback polynomial of the serial signature register.
REQ-003: Parameter SEED, 16'h0000, initial signature value.
REQ-004: Parameter GOLDEN, 16'h0000, expected final signature.
REQ-005: Parameter EXP_BITS, 16'd0, expected number of compacted bits.
REQ-006: clk  input  1  single system clock; all state updates on the rising edge.
REQ-007: rst  input  1  reset, asynchronous and active-low.
REQ-008: running  input  1  upstream BIST engine RUNNING; bist_out is valid in every cycle where running=1.
REQ-009: bist_out  input  1  serial test-response bit (upstream OUT).
REQ-010: bist_end  input  1  upstream BIST_END; single- or multi-cycle pulse marking the end of the session.
REQ-011: signature  output  SIG_W  current signature register contents.
REQ-012: bit_count  output  16  number of bits compacted in the current session.
REQ-013: done  output  1  verdict valid.
REQ-014: pass  output  1  verdict: signature and bit count both match.
REQ-015: fail  output  1  verdict: mismatch; pass and fail are never 1 simultaneously.

Function
REQ-016: The FSM shall have four states, IDLE, COMPACT, COMPARE and DONE, and shall be encoded in a 2-bit register.
REQ-017: The step function shall be step(s,b): fb = s[SIG_W-1] ^ b; s' = {s[SIG_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-018: In IDLE with running=1, the block shall set signature <= step(SEED, bist_out) and bit_count <= 1, then move to COMPACT; IDLE with running=0 shall hold.
REQ-019: In COMPACT with running=1, the block shall set signature <= step(signature, bist_out) and increment bit_count, saturating at 16'hFFFF.
REQ-020: In COMPACT with running=0 and bist_end=0, the block shall pause and hold signature and bit_count unchanged, with no timeout.
REQ-021: In COMPACT with bist_end=1, the block shall move to COMPARE; if running=1 in the same cycle, that cycle's bit shall be compacted first.
REQ-022: In COMPARE, exactly one cycle, the block shall set pass <= (signature==GOLDEN && bit_count==EXP_BITS), set fail <= the complement of pass, set done <= 1, and move to DONE.
REQ-023: The latency from the first bist_end=1 sample in COMPACT to done=1 shall be 2 clock cycles.
REQ-024: DONE shall hold done, pass, fail, signature and bit_count stable while running=0, and shall ignore further bist_end pulses.
REQ-025: In DONE with running=1, the block shall clear done, pass and fail, restart the signature from SEED with the current bit per REQ-018 (bit_count=1), and enter COMPACT in the same cycle.
REQ-026: In IDLE, bist_end=1 without a preceding running=1 shall be ignored (no verdict is produced).
REQ-027: The outputs pass, fail and done shall be registered, with no combinational path from any input.

Reset
REQ-028: With rst=0, the block shall asynchronously force state=IDLE, signature=SEED, bit_count=0, done=0, pass=0 and fail=0.
REQ-029: An assertion of rst mid-session (in COMPACT or COMPARE) shall discard the partial signature, and no verdict shall be produced until a new full session completes.
REQ-030: On release of rst, the block shall take its first state change on the first rising clk edge where rst=1.

Verification
REQ-031: Reset, then running=1 for 1 cycle with bist_out=1, then bist_end=1 -> signature=16'h1021 and bit_count=1; with GOLDEN=16'h1021 and EXP_BITS=1, done=1 and pass=1 two cycles after bist_end.
REQ-032: Two bits 1,1 under running=1, then bist_end -> signature=16'h3063 and bit_count=2; with GOLDEN=16'h1021, fail=1 and pass=0.
REQ-033: Bits 1,(running=0 for 5 cycles),1, then bist_end -> signature=16'h3063 and bit_count=2 (the pause does not alter state).
REQ-034: running=1 coincident with bist_end=1 on the last bit -> that bit is included (bit_count counts it); pulse bist_end again in DONE -> the verdict is unchanged.
REQ-035: rst=0 asserted mid-COMPACT between clock edges -> all outputs reach their reset values immediately; a subsequent full session produces a correct verdict.
REQ-036: Complete one session to DONE, then raise running=1 -> done=0 in the next cycle, and a second session with a different bit stream produces an independent verdict.

Source files
------------

// File: rtl/bist_signature_checker.sv
// rtl/bist_signature_checker.sv - serial BIST response compactor with golden signature verdict
//
// Purpose:
//   Compacts the serial response stream of an upstream BIST engine into a
//   SIG_W-bit signature register. It also counts the compacted bits. When the
//   engine signals the end of the session, it compares the signature and the
//   bit count against GOLDEN / EXP_BITS and then holds a registered verdict.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   running    in   1      upstream engine running; bist_out valid when high
//   bist_out   in   1      serial response bit
//   bist_end   in   1      end-of-session pulse (one or more cycles)
//   signature  out  SIG_W  current signature register
//   bit_count  out  16     bits compacted this session (saturating)
//   done       out  1      verdict valid
//   pass       out  1      signature and bit count matched
//   fail       out  1      mismatch (never high together with pass)
module bist_signature_checker #(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = 16'h1021,
  parameter logic [SIG_W-1:0] SEED     = 16'h0000,
  parameter logic [SIG_W-1:0] GOLDEN   = 16'h0000,
  parameter logic [15:0]      EXP_BITS = 16'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             running,
  input  logic             bist_out,
  input  logic             bist_end,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      bit_count,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [SIG_W-1:0] sig_q, sig_n;
  logic [15:0]      cnt_q, cnt_n;
  logic             done_q, done_n;
  logic             pass_q, pass_n;
  logic             fail_q, fail_n;
  logic             match;

  // One shift of the serial signature register. The incoming bit is folded
  // into the feedback tap, so the register compacts one bit per clock.
  function automatic logic [SIG_W-1:0] step(input logic [SIG_W-1:0] s,
                                            input logic             b);
    logic fb;
    fb = s[SIG_W-1] ^ b;
    return {s[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign match = (sig_q == GOLDEN) && (cnt_q == EXP_BITS);

  always_comb begin
    state_n = state_q;
    sig_n   = sig_q;
    cnt_n   = cnt_q;
    done_n  = done_q;
    pass_n  = pass_q;
    fail_n  = fail_q;
    case (state_q)
      IDLE: begin
        // bist_end alone is ignored here: there is no session to judge.
        if (running) begin
          sig_n   = step(SEED, bist_out);
          cnt_n   = 16'd1;
          state_n = COMPACT;
        end
      end
      COMPACT: begin
        // A bit arriving with bist_end is still part of the session.
        if (running) begin
          sig_n = step(sig_q, bist_out);
          cnt_n = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
        if (bist_end) begin
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        pass_n  = match;
        fail_n  = !match;
        done_n  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        // A new session restarts from SEED. Its first bit is taken in this
        // same cycle, so no input bit is lost.
        if (running) begin
          done_n  = 1'b0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          sig_n   = step(SEED, bist_out);
          cnt_n   = 16'd1;
          state_n = COMPACT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= 16'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sig_q   <= sig_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      fail_q  <= fail_n;
    end
  end

  assign signature = sig_q;
  assign bit_count = cnt_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// tb/tb_bist_signature_checker.sv - self-checking bench for bist_signature_checker
module tb_bist_signature_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        running;
  logic        bist_out;
  logic        bist_end;
  logic [15:0] signature;
  logic [15:0] bit_count;
  logic        done;
  logic        pass;
  logic        fail;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bist_signature_checker #(
    .SIG_W   (16),
    .POLY    (16'h1021),
    .SEED    (16'h0000),
    .GOLDEN  (16'h1021),
    .EXP_BITS(16'd1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .running  (running),
    .bist_out (bist_out),
    .bist_end (bist_end),
    .signature(signature),
    .bit_count(bit_count),
    .done     (done),
    .pass     (pass),
    .fail     (fail)
  );

  typedef struct {
    int          n;
    logic [7:0]  bits;   // bits[0] is sent first
    logic        coinc;  // bist_end rides on the last bit
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        pass;
    string       tag;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed(input logic b, input logic end_now);
    running  = 1'b1;
    bist_out = b;
    bist_end = end_now;
    tick();
    running  = 1'b0;
    bist_out = 1'b0;
    bist_end = 1'b0;
  endtask

  task automatic close(input logic coinc, input logic [15:0] esig,
                       input logic [15:0] ecnt, input logic epass,
                       input string tag);
    if (!coinc) begin
      bist_end = 1'b1;
      tick();
      bist_end = 1'b0;
    end
    check({tag, " done one cycle after end"}, done, 1'b0);
    tick();
    check({tag, " done"}, done, 1'b1);
    check({tag, " pass"}, pass, epass);
    check({tag, " fail"}, fail, !epass);
    check({tag, " signature"}, signature, esig);
    check({tag, " bit_count"}, bit_count, ecnt);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      feed(v.bits[i], v.coinc && (i == v.n - 1));
      if (i == 0) begin
        check({v.tag, " first bit count"}, bit_count, 16'd1);
        check({v.tag, " done cleared"}, done, 1'b0);
      end
    end
    close(v.coinc, v.sig, v.cnt, v.pass, v.tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 8'b0000_0001, 1'b0, 16'h1021, 16'd1, 1'b1, "v0_one"};
    vecs[1] = '{2, 8'b0000_0011, 1'b0, 16'h3063, 16'd2, 1'b0, "v1_11"};
    vecs[2] = '{1, 8'b0000_0000, 1'b0, 16'h0000, 16'd1, 1'b0, "v2_zero"};
    vecs[3] = '{2, 8'b0000_0010, 1'b1, 16'h1021, 16'd2, 1'b0, "v3_01_coinc"};
    vecs[4] = '{2, 8'b0000_0001, 1'b0, 16'h2042, 16'd2, 1'b0, "v4_10"};
    vecs[5] = '{3, 8'b0000_0111, 1'b1, 16'h70E7, 16'd3, 1'b0, "v5_111_coinc"};
    vecs[6] = '{3, 8'b0000_0001, 1'b0, 16'h4084, 16'd3, 1'b0, "v6_100"};
    vecs[7] = '{1, 8'b0000_0001, 1'b0, 16'h1021, 16'd1, 1'b1, "v7_one_again"};

    rst      = 1'b0;
    running  = 1'b0;
    bist_out = 1'b0;
    bist_end = 1'b0;
    tick();
    tick();
    check("reset signature", signature, 16'h0000);
    check("reset bit_count", bit_count, 16'd0);
    check("reset done", done, 1'b0);
    check("reset pass", pass, 1'b0);
    check("reset fail", fail, 1'b0);
    rst = 1'b1;

    // bist_end in IDLE without a session gives no verdict
    bist_end = 1'b1;
    repeat (3) tick();
    bist_end = 1'b0;
    tick();
    check("idle end done", done, 1'b0);
    check("idle end bit_count", bit_count, 16'd0);

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
    end

    // pause inside a session leaves the state untouched
    feed(1'b1, 1'b0);
    repeat (5) tick();
    check("pause signature", signature, 16'h1021);
    check("pause bit_count", bit_count, 16'd1);
    check("pause done", done, 1'b0);
    feed(1'b1, 1'b0);
    close(1'b0, 16'h3063, 16'd2, 1'b0, "pause");

    // DONE holds and ignores extra bist_end pulses
    bist_end = 1'b1;
    tick();
    bist_end = 1'b0;
    tick();
    bist_end = 1'b1;
    repeat (2) tick();
    bist_end = 1'b0;
    tick();
    check("hold done", done, 1'b1);
    check("hold pass", pass, 1'b0);
    check("hold fail", fail, 1'b1);
    check("hold signature", signature, 16'h3063);
    check("hold bit_count", bit_count, 16'd2);

    // asynchronous reset in the middle of COMPACT
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b0);
    check("pre reset signature", signature, 16'h3063);
    #2 rst = 1'b0;
    #1;
    check("async signature", signature, 16'h0000);
    check("async bit_count", bit_count, 16'd0);
    check("async done", done, 1'b0);
    check("async pass", pass, 1'b0);
    check("async fail", fail, 1'b0);
    #2 rst = 1'b1;
    bist_end = 1'b1;
    repeat (3) tick();
    bist_end = 1'b0;
    tick();
    check("post reset no verdict", done, 1'b0);
    feed(1'b1, 1'b0);
    close(1'b0, 16'h1021, 16'd1, 1'b1, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
